video_timing_receiver: RTL and testbench

//  Sink-side counterpart of video_transmitter: consumes raw hSync/vSync, recovers pixel/line position,

---
 rtl/video_timing_pkg.sv | 31 +++
 rtl/video_timing_receiver_sync_edge_detect.sv | 39 +++
 rtl/video_timing_receiver.sv | 193 +++++++++++++++++++
 tb/tb_video_timing_receiver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_pkg                                                           |
// | 640x480@60 mode constants, counter widths and receiver FSM states.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

  localparam int unsigned VGA_H_SYNC_W = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_SYNC_W = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;

  localparam int unsigned HPOS_W   = 11;
  localparam int unsigned VPOS_W   = 10;
  localparam int unsigned PIX_W    = 10;
  localparam int unsigned GOOD_W   = 4;
  localparam int unsigned HPOS_SAT = (1 << HPOS_W) - 1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vt_state_e;

endpackage
`default_nettype wire

// File: rtl/video_timing_receiver_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_edge_detect                                                           |
// | Two-flop synchroniser, polarity normalisation and registered rising edge. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_edge_detect #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_d3;
  logic r_rise;

  // Stored already normalised to active-high, so reset value 0 is the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_d3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_sync ^ ~SYNC_POL;
      r_s2   <= r_s1;
      r_d3   <= r_s2;
      r_rise <= r_s2 & ~r_d3;
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/video_timing_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_receiver                                                      |
// | Recovers raster position from hSync/vSync, measures timing, tracks lock.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_timing_receiver
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC_W    = VGA_H_SYNC_W,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_SYNC_W    = VGA_V_SYNC_W,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              pixelCLK,
  input  logic              resetN,
  input  logic              hSync,
  input  logic              vSync,
  output logic [HPOS_W-1:0] hPos,
  output logic [VPOS_W-1:0] vPos,
  output logic [PIX_W-1:0]  pixelX,
  output logic [PIX_W-1:0]  pixelY,
  output logic              activeVideo,
  output logic [HPOS_W-1:0] measHTotal,
  output logic [VPOS_W-1:0] measVTotal,
  output logic              locked,
  output logic              timingError
);

  localparam int unsigned H_START = H_SYNC_W + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC_W + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  logic w_hs_rise;
  logic w_vs_rise;

  sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk    (pixelCLK),
    .rst_n  (resetN),
    .i_sync (hSync),
    .o_rise (w_hs_rise)
  );

  sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk    (pixelCLK),
    .rst_n  (resetN),
    .i_sync (vSync),
    .o_rise (w_vs_rise)
  );

  vt_state_e          r_state;
  vt_state_e          w_state_nxt;
  logic [GOOD_W-1:0]  r_good;
  logic [GOOD_W-1:0]  w_good_nxt;
  logic [GOOD_W-1:0]  w_good_inc;
  logic [HPOS_W-1:0]  r_h;
  logic [VPOS_W-1:0]  r_v;
  logic [HPOS_W-1:0]  r_mh;
  logic [VPOS_W-1:0]  r_mv;
  logic [PIX_W-1:0]   r_px;
  logic [PIX_W-1:0]   r_py;
  logic               r_active;
  logic               r_locked;
  logic               r_terr;
  logic               r_line_bad;
  logic               r_vs_pend;

  logic [HPOS_W:0]    w_h_ext;
  logic [HPOS_W-1:0]  w_h_inc;
  logic [VPOS_W-1:0]  w_v_inc;
  logic [HPOS_W-1:0]  w_h_nxt;
  logic [VPOS_W-1:0]  w_v_nxt;
  logic               w_vs_pend;
  logic               w_frame;
  logic               w_line_bad;
  logic               w_frame_good;
  logic               w_sat_err;
  logic               w_err;
  logic               w_in_h;
  logic               w_in_v;
  logic               w_active_nxt;

  // Unsaturated line length so a saturated hPos can never alias onto H_TOTAL.
  assign w_h_ext      = {1'b0, r_h} + {{HPOS_W{1'b0}}, 1'b1};
  assign w_h_inc      = (r_h == HPOS_W'(HPOS_SAT)) ? r_h : r_h + 1'b1;
  assign w_v_inc      = (r_v == '1) ? r_v : r_v + 1'b1;
  assign w_vs_pend    = r_vs_pend | w_vs_rise;
  assign w_frame      = w_hs_rise & w_vs_pend;
  assign w_line_bad   = w_hs_rise & (w_h_ext != (HPOS_W + 1)'(H_TOTAL));
  assign w_frame_good = ~(r_line_bad | w_line_bad) & (w_v_inc == VPOS_W'(V_TOTAL));
  assign w_sat_err    = ~w_hs_rise & (r_h == HPOS_W'(HPOS_SAT - 1));
  assign w_good_inc   = r_good + 1'b1;

  assign w_h_nxt = w_hs_rise ? '0 : w_h_inc;
  assign w_v_nxt = w_frame ? '0 : (w_hs_rise ? w_v_inc : r_v);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_frame) begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = '0;
        end
      end
      ST_MEASURE: begin
        if (w_frame) begin
          if (w_frame_good) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == GOOD_W'(LOCK_FRAMES)) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_line_bad || (w_frame && !w_frame_good) || w_sat_err) begin
          w_err       = 1'b1;
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  // Window decode works on next-cycle positions so it lines up with hPos/vPos.
  assign w_in_h       = (w_h_nxt >= HPOS_W'(H_START)) && (w_h_nxt < HPOS_W'(H_END));
  assign w_in_v       = (w_v_nxt >= VPOS_W'(V_START)) && (w_v_nxt < VPOS_W'(V_END));
  assign w_active_nxt = (w_state_nxt == ST_LOCKED) && w_in_h && w_in_v;

  always_ff @(posedge pixelCLK or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_SEARCH;
      r_good     <= '0;
      r_h        <= '0;
      r_v        <= '0;
      r_mh       <= '0;
      r_mv       <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_active   <= 1'b0;
      r_locked   <= 1'b0;
      r_terr     <= 1'b0;
      r_line_bad <= 1'b0;
      r_vs_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good     <= w_good_nxt;
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      if (w_hs_rise) begin
        r_mh <= w_h_inc;
      end
      if (w_frame) begin
        r_mv <= w_v_inc;
      end
      r_line_bad <= w_frame ? 1'b0 : (r_line_bad | w_line_bad);
      r_vs_pend  <= w_hs_rise ? 1'b0 : w_vs_pend;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_terr     <= w_err;
      r_active   <= w_active_nxt;
      r_px       <= w_active_nxt ? PIX_W'(w_h_nxt - HPOS_W'(H_START)) : '0;
      r_py       <= w_active_nxt ? PIX_W'(w_v_nxt - VPOS_W'(V_START)) : '0;
    end
  end

  assign hPos        = r_h;
  assign vPos        = r_v;
  assign pixelX      = r_px;
  assign pixelY      = r_py;
  assign activeVideo = r_active;
  assign measHTotal  = r_mh;
  assign measVTotal  = r_mv;
  assign locked      = r_locked;
  assign timingError = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_timing_receiver                                                   |
// | Reduced-size raster into active-low and active-high receivers vs a model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_video_timing_receiver;

  localparam int HS = 6;
  localparam int HB = 4;
  localparam int HA = 24;
  localparam int HT = 40;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 12;
  localparam int VT = 20;
  localparam int LF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN;
  logic hs_lo, vs_lo, hs_hi, vs_hi;
  bit   act_h, act_v;

  logic [10:0] o_h  [2];
  logic [10:0] o_mh [2];
  logic [9:0]  o_v  [2];
  logic [9:0]  o_px [2];
  logic [9:0]  o_py [2];
  logic [9:0]  o_mv [2];
  logic        o_av [2];
  logic        o_lk [2];
  logic        o_err[2];

  video_timing_receiver #(
    .H_SYNC_W(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC_W(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) u_dut_lo (
    .pixelCLK(clk), .resetN(resetN), .hSync(hs_lo), .vSync(vs_lo),
    .hPos(o_h[0]), .vPos(o_v[0]), .pixelX(o_px[0]), .pixelY(o_py[0]),
    .activeVideo(o_av[0]), .measHTotal(o_mh[0]), .measVTotal(o_mv[0]),
    .locked(o_lk[0]), .timingError(o_err[0])
  );

  video_timing_receiver #(
    .H_SYNC_W(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC_W(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
  ) u_dut_hi (
    .pixelCLK(clk), .resetN(resetN), .hSync(hs_hi), .vSync(vs_hi),
    .hPos(o_h[1]), .vPos(o_v[1]), .pixelX(o_px[1]), .pixelY(o_py[1]),
    .activeVideo(o_av[1]), .measHTotal(o_mh[1]), .measVTotal(o_mv[1]),
    .locked(o_lk[1]), .timingError(o_err[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: timestamps of sync events seen through a 3-cycle detection delay.
  int m_n, m_last, m_lines, m_mode, m_good, m_mh, m_mv;
  bit m_vspend, m_lbad, m_err;
  bit hh[5], hv[5];
  int n_err0 = 0;
  bit seen_lock = 0;
  int lock_at = -1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    m_n = 0; m_last = 0; m_lines = 0; m_mode = 0; m_good = 0;
    m_mh = 0; m_mv = 0; m_vspend = 0; m_lbad = 0; m_err = 0;
    for (int i = 0; i < 5; i++) begin hh[i] = 0; hv[i] = 0; end
  endtask

  task automatic m_step();
    bit hs_evt, vs_evt, frame, lb, fbad, sat;
    int len;
    m_n++;
    for (int i = 0; i < 4; i++) begin hh[i] = hh[i+1]; hv[i] = hv[i+1]; end
    hh[4] = act_h; hv[4] = act_v;
    hs_evt = hh[1] && !hh[0];
    vs_evt = hv[1] && !hv[0];
    len    = m_n - m_last;
    frame  = hs_evt && (m_vspend || vs_evt);
    lb = 0; fbad = 0; m_err = 0;
    if (vs_evt) m_vspend = 1;
    if (hs_evt) begin
      lb     = (len != HT);
      m_mh   = imin(len, 2047);
      m_last = m_n;
      if (frame) begin
        m_mv    = imin(m_lines + 1, 1023);
        fbad    = m_lbad || lb || (m_mv != VT);
        m_lines = 0;
        m_lbad  = 0;
      end else begin
        m_lines++;
        m_lbad = m_lbad || lb;
      end
      m_vspend = 0;
    end
    sat = !hs_evt && (len == 2047);
    if (m_mode == 2) begin
      if ((hs_evt && lb) || (frame && fbad) || sat) begin
        m_err = 1; m_mode = 0; m_good = 0;
      end
    end else if (frame) begin
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else if (fbad) begin
        m_good = 0;
      end else begin
        m_good++;
        if (m_good == LF) m_mode = 2;
      end
    end
  endtask

  task automatic compare_all();
    int  eh, ev, ex, ey;
    bit  elk, eav;
    eh  = imin(m_n - m_last, 2047);
    ev  = imin(m_lines, 1023);
    elk = (m_mode == 2);
    eav = elk && eh >= HS + HB && eh < HS + HB + HA && ev >= VS + VB && ev < VS + VB + VA;
    ex  = eav ? eh - (HS + HB) : 0;
    ey  = eav ? ev - (VS + VB) : 0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("hPos[%0d]", d), o_h[d], eh);
      chk($sformatf("vPos[%0d]", d), o_v[d], ev);
      chk($sformatf("pixelX[%0d]", d), o_px[d], ex);
      chk($sformatf("pixelY[%0d]", d), o_py[d], ey);
      chk($sformatf("activeVideo[%0d]", d), o_av[d], eav);
      chk($sformatf("measHTotal[%0d]", d), o_mh[d], m_mh);
      chk($sformatf("measVTotal[%0d]", d), o_mv[d], m_mv);
      chk($sformatf("locked[%0d]", d), o_lk[d], elk);
      chk($sformatf("timingError[%0d]", d), o_err[d], m_err);
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!resetN) m_reset(); else m_step();
      @(negedge clk);
      if (!resetN) m_reset();
      compare_all();
      if (o_err[0] === 1'b1) n_err0++;
      if (!seen_lock && o_lk[0] === 1'b1) begin seen_lock = 1; lock_at = m_n; end
    end
  end

  task automatic drive(input bit h, input bit v);
    act_h = h; act_v = v;
    hs_lo = ~h; vs_lo = ~v;
    hs_hi = h;  vs_hi = v;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int len, input bit v);
    for (int c = 0; c < len; c++) drive(c < HS, v);
  endtask

  task automatic frame(input int nl, input int bad_line, input int bad_len);
    for (int l = 0; l < nl; l++) line((l == bad_line) ? bad_len : HT, l < VS);
  endtask

  task automatic wait_pos(input int h, input int v);
    int k;
    k = 0;
    while (!(o_h[0] == h && o_v[0] == v) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_total++; n_bad++;
      $display("FAIL wait_pos h=%0d v=%0d not reached", h, v);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int e0;
    resetN = 1'b0;
    for (int i = 0; i < 4; i++) drive(0, 0);
    chk("reset_locked", o_lk[0], 0);
    chk("reset_measH", o_mh[0], 0);
    resetN = 1'b1;

    // Clean stream: lock after two complete frames.
    for (int f = 0; f < 3; f++) frame(VT, -1, HT);
    chk("lock_latency", lock_at, 2 * HT * VT + 4);
    chk("lock_measH", o_mh[0], HT);
    chk("lock_measV", o_mv[0], VT);
    chk("lock_pol_hi", o_lk[1], 1);

    fork
      frame(VT, -1, HT);
      begin
        wait_pos(HS + HB, VS + VB);
        for (int d = 0; d < 2; d++) begin
          chk("first_pixel_av", o_av[d], 1);
          chk("first_pixel_x", o_px[d], 0);
          chk("first_pixel_y", o_py[d], 0);
        end
        wait_pos(HS + HB + HA - 1, VS + VB + VA - 1);
        chk("last_pixel_x", o_px[0], HA - 1);
        chk("last_pixel_y", o_py[0], VA - 1);
        chk("last_pixel_av", o_av[1], 1);
      end
    join

    // One stretched line while locked.
    e0 = n_err0;
    frame(VT, 7, HT + 1);
    chk("stretch_err_pulses", n_err0 - e0, 1);
    chk("stretch_unlocked", o_lk[0], 0);
    for (int f = 0; f < 3; f++) frame(VT, -1, HT);
    chk("relock_after_stretch", o_lk[0], 1);

    // hSync stuck inactive.
    e0 = n_err0;
    for (int i = 0; i < 3000; i++) drive(0, 0);
    chk("stuck_hpos_sat", o_h[0], 2047);
    chk("stuck_unlocked", o_lk[0], 0);
    chk("stuck_err_pulses", n_err0 - e0, 1);
    for (int f = 0; f < 3; f++) frame(VT, -1, HT);
    chk("relock_after_stuck", o_lk[0], 1);

    // Mid-frame reset.
    for (int l = 0; l < 5; l++) line(HT, l < VS);
    resetN = 1'b0;
    @(negedge clk);
    chk("midreset_locked", o_lk[0], 0);
    chk("midreset_hpos", o_h[0], 0);
    chk("midreset_measV", o_mv[1], 0);
    for (int i = 0; i < 3; i++) drive(0, 0);
    resetN = 1'b1;
    frame(VT, -1, HT);
    frame(VT, -1, HT);
    chk("no_early_relock", o_lk[0], 0);
    frame(VT, -1, HT);
    chk("relock_after_reset", o_lk[0], 1);

    // Randomised frames: occasional line-length and line-count perturbations.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        frame(VT, -1, HT);
      end else begin
        frame(VT - 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, VT - 1)),
              HT - 2 + int'($urandom_range(0, 4)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
